// File: rtl/fpu_mul_pkg.sv
// Shared constants for the floating-point multiply unit: FSM state codes,
// rounding-mode encodings and exponent bias/limit helpers.
package fpu_mul_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MULT  = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ROUND = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [1:0] {
    RM_NEAREST_EVEN = 2'b00,
    RM_TOWARD_ZERO  = 2'b01,
    RM_TOWARD_POS   = 2'b10,
    RM_TOWARD_NEG   = 2'b11
  } round_mode_e;

  function automatic int exp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Smallest biased exponent that no longer encodes a finite number.
  function automatic int exp_limit(input int ew);
    return (1 << ew) - 1;
  endfunction

endpackage

// File: rtl/fpu_mul_if.sv
// Requester/unit bundle for the multiply unit: start/ack handshake,
// operands, rounding mode, and the held result with its flags.
interface fpu_mul_if #(parameter int W = 32) ();
  logic         beg_FSM;
  logic         ack_FSM;
  logic [W-1:0] Data_MX;
  logic [W-1:0] Data_MY;
  logic [1:0]   round_mode;
  logic         overflow_flag;
  logic         underflow_flag;
  logic         ready;
  logic [W-1:0] final_result_ieee;

  modport master (
    output beg_FSM, ack_FSM, Data_MX, Data_MY, round_mode,
    input  overflow_flag, underflow_flag, ready, final_result_ieee
  );

  modport slave (
    input  beg_FSM, ack_FSM, Data_MX, Data_MY, round_mode,
    output overflow_flag, underflow_flag, ready, final_result_ieee
  );
endinterface

// File: rtl/fpu_mul_round.sv
// Final stage of the multiplier: guard/sticky rounding, carry renormalisation
// and classification into normal / zero / infinity / quiet NaN.
module fpu_mul_round
  import fpu_mul_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic                 i_sign,
  input  logic                 i_zero,
  input  logic                 i_nan,
  input  logic                 i_inf,
  input  logic [1:0]           i_round_mode,
  input  logic [SW-1:0]        i_mant,
  input  logic                 i_guard,
  input  logic                 i_sticky,
  input  logic signed [EW+1:0] i_exp,
  output logic [W-1:0]         o_result,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam logic signed [EW+1:0] EXP_LIMIT = (EW+2)'(exp_limit(EW));

  logic                 w_inc;
  logic                 w_inexact;
  logic [SW:0]          w_sum;
  logic [SW-1:0]        w_frac;
  logic signed [EW+1:0] w_exp_r;
  logic                 w_ovf;
  logic                 w_unf;

  always_comb begin
    w_inexact = i_guard | i_sticky;
    w_inc     = 1'b0;
    case (round_mode_e'(i_round_mode))
      RM_NEAREST_EVEN: w_inc = i_guard & (i_sticky | i_mant[0]);
      RM_TOWARD_ZERO:  w_inc = 1'b0;
      RM_TOWARD_POS:   w_inc = w_inexact & ~i_sign;
      RM_TOWARD_NEG:   w_inc = w_inexact & i_sign;
      default:         w_inc = 1'b0;
    endcase
  end

  // A carry out of the fraction means 1.11..1 rounded up to 10.0: fraction clears, exponent bumps.
  assign w_sum   = {1'b0, i_mant} + {{SW{1'b0}}, w_inc};
  assign w_exp_r = i_exp + $signed({{(EW+1){1'b0}}, w_sum[SW]});
  assign w_frac  = w_sum[SW] ? '0 : w_sum[SW-1:0];
  assign w_ovf   = !w_exp_r[EW+1] && (w_exp_r >= EXP_LIMIT);
  assign w_unf   = w_exp_r[EW+1] || (w_exp_r == '0);

  always_comb begin
    o_result    = {i_sign, w_exp_r[EW-1:0], w_frac};
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    if (i_nan) begin
      o_result = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
    end else if (i_inf) begin
      o_result = {i_sign, {EW{1'b1}}, {SW{1'b0}}};
    end else if (i_zero) begin
      o_result = {i_sign, {(W-1){1'b0}}};
    end else if (w_ovf) begin
      o_result   = {i_sign, {EW{1'b1}}, {SW{1'b0}}};
      o_overflow = 1'b1;
    end else if (w_unf) begin
      o_result    = {i_sign, {(W-1){1'b0}}};
      o_underflow = 1'b1;
    end
  end

endmodule

// File: rtl/fpu_multiplication_function.sv
// Multi-cycle IEEE-754 multiplier with begin/ready/acknowledge handshake.
// Define FPU_MUL_SPECIAL_EN to decode infinity/NaN operands.
module fpu_multiplication_function
  import fpu_mul_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic      clk,
  input  logic      rst,
  fpu_mul_if.slave  bus
);

  localparam int PW = 2*SW + 2;
  localparam logic signed [EW+1:0] BIAS    = (EW+2)'(exp_bias(EW));
  localparam logic signed [EW+1:0] EXP_ONE = (EW+2)'(1);

  logic [2:0]           r_state;
  logic [W-1:0]         r_x;
  logic [W-1:0]         r_y;
  logic [1:0]           r_rm;
  logic                 r_sign;
  logic                 r_zero;
  logic                 r_nan;
  logic                 r_inf;
  logic [PW-1:0]        r_prod;
  logic signed [EW+1:0] r_exp_sum;
  logic [SW-1:0]        r_mant;
  logic                 r_guard;
  logic                 r_sticky;
  logic signed [EW+1:0] r_nexp;
  logic [W-1:0]         r_result;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 r_ready;

  logic [EW-1:0] w_ex;
  logic [EW-1:0] w_ey;
  logic [SW-1:0] w_fx;
  logic [SW-1:0] w_fy;
  logic          w_x_zero;
  logic          w_y_zero;
  logic          w_nan;
  logic          w_inf;
  logic [PW-1:0] w_prod;
  logic [W-1:0]  w_result;
  logic          w_ovf;
  logic          w_unf;

  assign w_ex     = r_x[W-2:SW];
  assign w_ey     = r_y[W-2:SW];
  assign w_fx     = r_x[SW-1:0];
  assign w_fy     = r_y[SW-1:0];
  assign w_x_zero = ~|w_ex;
  assign w_y_zero = ~|w_ey;
  assign w_prod   = {{(SW+1){1'b0}}, 1'b1, w_fx} * {{(SW+1){1'b0}}, 1'b1, w_fy};

`ifdef FPU_MUL_SPECIAL_EN
  logic w_x_ones;
  logic w_y_ones;
  assign w_x_ones = &w_ex;
  assign w_y_ones = &w_ey;
  assign w_nan = (w_x_ones & |w_fx) | (w_y_ones & |w_fy)
               | (w_x_ones & w_y_zero) | (w_y_ones & w_x_zero);
  assign w_inf = w_x_ones | w_y_ones;
`else
  assign w_nan = 1'b0;
  assign w_inf = 1'b0;
`endif

  fpu_mul_round #(.W(W), .EW(EW), .SW(SW)) u_round (
    .i_sign       (r_sign),
    .i_zero       (r_zero),
    .i_nan        (r_nan),
    .i_inf        (r_inf),
    .i_round_mode (r_rm),
    .i_mant       (r_mant),
    .i_guard      (r_guard),
    .i_sticky     (r_sticky),
    .i_exp        (r_nexp),
    .o_result     (w_result),
    .o_overflow   (w_ovf),
    .o_underflow  (w_unf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_rm      <= '0;
      r_sign    <= 1'b0;
      r_zero    <= 1'b0;
      r_nan     <= 1'b0;
      r_inf     <= 1'b0;
      r_prod    <= '0;
      r_exp_sum <= '0;
      r_mant    <= '0;
      r_guard   <= 1'b0;
      r_sticky  <= 1'b0;
      r_nexp    <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.beg_FSM) begin
          r_x     <= bus.Data_MX;
          r_y     <= bus.Data_MY;
          r_rm    <= bus.round_mode;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_sign  <= r_x[W-1] ^ r_y[W-1];
          r_zero  <= w_x_zero | w_y_zero;
          r_nan   <= w_nan;
          r_inf   <= w_inf;
          r_state <= S_MULT;
        end
        S_MULT: begin
          r_prod    <= w_prod;
          r_exp_sum <= $signed({2'b00, w_ex}) + $signed({2'b00, w_ey}) - BIAS;
          r_state   <= S_NORM;
        end
        S_NORM: begin
          // Product of two [1,2) significands lies in [1,4); MSB set means shift right one.
          if (r_prod[PW-1]) begin
            r_mant   <= r_prod[PW-2:SW+1];
            r_guard  <= r_prod[SW];
            r_sticky <= |r_prod[SW-1:0];
            r_nexp   <= r_exp_sum + EXP_ONE;
          end else begin
            r_mant   <= r_prod[PW-3:SW];
            r_guard  <= r_prod[SW-1];
            r_sticky <= |r_prod[SW-2:0];
            r_nexp   <= r_exp_sum;
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_result <= w_result;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
          r_ready  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: if (bus.ack_FSM) begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready             = r_ready;
  assign bus.final_result_ieee = r_result;
  assign bus.overflow_flag     = r_ovf;
  assign bus.underflow_flag    = r_unf;

endmodule

// File: tb/tb_fpu_multiplication_function.sv
// Directed bench for the single- and double-precision multiplier builds.
module tb_fpu_multiplication_function;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_mul_if #(.W(32)) b32 ();
  fpu_mul_if #(.W(64)) b64 ();

  fpu_multiplication_function #(.W(32), .EW(8), .SW(23)) dut32 (
    .clk (clk), .rst (rst), .bus (b32)
  );
  fpu_multiplication_function #(.W(64), .EW(11), .SW(52)) dut64 (
    .clk (clk), .rst (rst), .bus (b64)
  );

  int checks   = 0;
  int failures = 0;

  task automatic run_op(input bit dbl, input logic [63:0] x, input logic [63:0] y,
                        input logic [1:0] rm, output int lat);
    int  seen;
    logic rdy;
    @(negedge clk);
    if (dbl) begin
      b64.Data_MX = x; b64.Data_MY = y; b64.round_mode = rm; b64.beg_FSM = 1'b1;
    end else begin
      b32.Data_MX = x[31:0]; b32.Data_MY = y[31:0]; b32.round_mode = rm; b32.beg_FSM = 1'b1;
    end
    @(negedge clk);
    seen = 1;
    // Operands must have been captured; scramble them to catch late sampling.
    b64.beg_FSM = 1'b0; b32.beg_FSM = 1'b0;
    b64.Data_MX = ~x; b64.Data_MY = ~y; b64.round_mode = ~rm;
    b32.Data_MX = ~x[31:0]; b32.Data_MY = ~y[31:0]; b32.round_mode = ~rm;
    rdy = dbl ? b64.ready : b32.ready;
    while (!rdy && seen < 20) begin
      @(negedge clk);
      seen++;
      rdy = dbl ? b64.ready : b32.ready;
    end
    lat = rdy ? seen - 1 : -1;
  endtask

  task automatic do_ack(input bit dbl);
    @(negedge clk);
    if (dbl) b64.ack_FSM = 1'b1; else b32.ack_FSM = 1'b1;
    @(negedge clk);
    b64.ack_FSM = 1'b0; b32.ack_FSM = 1'b0;
  endtask

  task automatic test_reset();
    b32.beg_FSM = 0; b32.ack_FSM = 0; b32.Data_MX = '0; b32.Data_MY = '0; b32.round_mode = 0;
    b64.beg_FSM = 0; b64.ack_FSM = 0; b64.Data_MX = '0; b64.Data_MY = '0; b64.round_mode = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (b32.ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", b32.ready); end
    checks++; if (b32.final_result_ieee !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", b32.final_result_ieee); end
    checks++; if ({b32.overflow_flag, b32.underflow_flag} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b expected 00", {b32.overflow_flag, b32.underflow_flag}); end
    checks++; if (b64.ready !== 1'b0 || b64.final_result_ieee !== 64'h0) begin failures++; $display("FAIL reset_dbl: got %b/%h expected 0/0", b64.ready, b64.final_result_ieee); end
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    int lat;
    run_op(0, 64'h40400000, 64'h40000000, 2'b00, lat);
    $display("op 40400000 x 40000000 rm=00 -> %h lat=%0d", b32.final_result_ieee, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    checks++; if (b32.final_result_ieee !== 32'h40C00000) begin failures++; $display("FAIL basic_result: got %h expected 40C00000", b32.final_result_ieee); end
    checks++; if ({b32.overflow_flag, b32.underflow_flag} !== 2'b00) begin failures++; $display("FAIL basic_flags: got %b expected 00", {b32.overflow_flag, b32.underflow_flag}); end
    do_ack(0);
    checks++; if (b32.ready !== 1'b0) begin failures++; $display("FAIL basic_ack: got ready=%b expected 0", b32.ready); end
  endtask

  task automatic test_rounding();
    logic [1:0]  modes [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [31:0] exp_r [4] = '{32'h3F800002, 32'h3F800003, 32'h3F800002, 32'h3F800002};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(0, 64'h3F800001, 64'h3F800001, modes[i], lat);
      $display("op 3F800001 x 3F800001 rm=%b -> %h", modes[i], b32.final_result_ieee);
      checks++; if (b32.final_result_ieee !== exp_r[i]) begin failures++; $display("FAIL round_rm%b: got %h expected %h", modes[i], b32.final_result_ieee, exp_r[i]); end
      do_ack(0);
    end
  endtask

  task automatic test_range();
    int lat;
    run_op(0, 64'h7F000000, 64'h7F000000, 2'b00, lat);
    $display("op 7F000000 x 7F000000 -> %h ovf=%b unf=%b", b32.final_result_ieee, b32.overflow_flag, b32.underflow_flag);
    checks++; if (b32.final_result_ieee !== 32'h7F800000) begin failures++; $display("FAIL ovf_result: got %h expected 7F800000", b32.final_result_ieee); end
    checks++; if ({b32.overflow_flag, b32.underflow_flag} !== 2'b10) begin failures++; $display("FAIL ovf_flags: got %b expected 10", {b32.overflow_flag, b32.underflow_flag}); end
    do_ack(0);
    run_op(0, 64'h00800000, 64'h00800000, 2'b00, lat);
    $display("op 00800000 x 00800000 -> %h ovf=%b unf=%b", b32.final_result_ieee, b32.overflow_flag, b32.underflow_flag);
    checks++; if (b32.final_result_ieee !== 32'h00000000) begin failures++; $display("FAIL unf_result: got %h expected 00000000", b32.final_result_ieee); end
    checks++; if ({b32.overflow_flag, b32.underflow_flag} !== 2'b01) begin failures++; $display("FAIL unf_flags: got %b expected 01", {b32.overflow_flag, b32.underflow_flag}); end
    do_ack(0);
    run_op(0, 64'h00000000, 64'hC0000000, 2'b00, lat);
    $display("op 00000000 x C0000000 -> %h ovf=%b unf=%b", b32.final_result_ieee, b32.overflow_flag, b32.underflow_flag);
    checks++; if (b32.final_result_ieee !== 32'h80000000) begin failures++; $display("FAIL zero_result: got %h expected 80000000", b32.final_result_ieee); end
    checks++; if ({b32.overflow_flag, b32.underflow_flag} !== 2'b00) begin failures++; $display("FAIL zero_flags: got %b expected 00", {b32.overflow_flag, b32.underflow_flag}); end
    do_ack(0);
  endtask

  task automatic test_double();
    int lat;
    run_op(1, 64'h4008000000000000, 64'h4000000000000000, 2'b00, lat);
    $display("op64 4008000000000000 x 4000000000000000 -> %h lat=%0d", b64.final_result_ieee, lat);
    checks++; if (b64.final_result_ieee !== 64'h4018000000000000) begin failures++; $display("FAIL dbl_result: got %h expected 4018000000000000", b64.final_result_ieee); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL dbl_latency: got %0d expected 4", lat); end
    do_ack(1);
    checks++; if (b64.ready !== 1'b0) begin failures++; $display("FAIL dbl_ack: got ready=%b expected 0", b64.ready); end
  endtask

  task automatic test_handshake();
    int lat;
    run_op(0, 64'h40400000, 64'h40000000, 2'b00, lat);
    $display("op hold 40400000 x 40000000 -> %h", b32.final_result_ieee);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (b32.ready !== 1'b1 || b32.final_result_ieee !== 32'h40C00000) begin failures++; $display("FAIL hold_c%0d: got %b/%h expected 1/40C00000", i, b32.ready, b32.final_result_ieee); end
    end
    b32.Data_MX = 32'h3F800000; b32.Data_MY = 32'h3F800000; b32.beg_FSM = 1'b1;
    @(negedge clk);
    b32.beg_FSM = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (b32.ready !== 1'b1 || b32.final_result_ieee !== 32'h40C00000) begin failures++; $display("FAIL beg_in_done: got %b/%h expected 1/40C00000", b32.ready, b32.final_result_ieee); end
    b32.ack_FSM = 1'b1; b32.beg_FSM = 1'b1;
    @(negedge clk);
    b32.ack_FSM = 1'b0; b32.beg_FSM = 1'b0;
    checks++; if (b32.ready !== 1'b0) begin failures++; $display("FAIL ack_with_beg: got ready=%b expected 0", b32.ready); end
    repeat (6) @(negedge clk);
    checks++; if (b32.ready !== 1'b0) begin failures++; $display("FAIL beg_not_taken: got ready=%b expected 0", b32.ready); end
    checks++; if (b32.final_result_ieee !== 32'h40C00000) begin failures++; $display("FAIL idle_hold: got %h expected 40C00000", b32.final_result_ieee); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    b32.Data_MX = 32'h3F800001; b32.Data_MY = 32'h3F800001; b32.beg_FSM = 1'b1;
    @(negedge clk);
    b32.beg_FSM = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("reset asserted mid-operation");
    checks++; if (b32.final_result_ieee !== 32'h0 || b32.ready !== 1'b0) begin failures++; $display("FAIL midrst_out: got %b/%h expected 0/00000000", b32.ready, b32.final_result_ieee); end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (b32.ready !== 1'b0) begin failures++; $display("FAIL midrst_abort: got ready=%b expected 0", b32.ready); end
  endtask

  task automatic test_special();
    int lat;
    logic [31:0] e1, e2;
    logic [1:0]  f2;
`ifdef FPU_MUL_SPECIAL_EN
    e1 = 32'h7FC00000; e2 = 32'hFF800000; f2 = 2'b00;
`else
    e1 = 32'h00000000; e2 = 32'hFF800000; f2 = 2'b10;
`endif
    run_op(0, 64'h7F800000, 64'h00000000, 2'b00, lat);
    $display("op 7F800000 x 00000000 -> %h", b32.final_result_ieee);
    checks++; if (b32.final_result_ieee !== e1) begin failures++; $display("FAIL inf_x_zero: got %h expected %h", b32.final_result_ieee, e1); end
    checks++; if ({b32.overflow_flag, b32.underflow_flag} !== 2'b00) begin failures++; $display("FAIL inf_x_zero_flags: got %b expected 00", {b32.overflow_flag, b32.underflow_flag}); end
    do_ack(0);
    run_op(0, 64'hFF800000, 64'h40000000, 2'b00, lat);
    $display("op FF800000 x 40000000 -> %h ovf=%b", b32.final_result_ieee, b32.overflow_flag);
    checks++; if (b32.final_result_ieee !== e2) begin failures++; $display("FAIL ninf_x_two: got %h expected %h", b32.final_result_ieee, e2); end
    checks++; if ({b32.overflow_flag, b32.underflow_flag} !== f2) begin failures++; $display("FAIL ninf_x_two_flags: got %b expected %b", {b32.overflow_flag, b32.underflow_flag}, f2); end
    do_ack(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_range();
    test_double();
    test_handshake();
    test_reset_mid();
    test_basic();
    test_special();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
